// File: rtl/button_repeater.sv
// Per-channel press / auto-repeat / release pulse generator for debounced buttons.
// Every output is registered. Each channel runs its own small FSM and counter.
//
// state     | meaning
// IDLE      | button released, no counting
// WAIT_HOLD | pressed, counting toward the first repeat (or parked while repeat is disabled)
// REPEAT    | held past the first repeat, counting toward the next one
module button_repeater #(
  parameter int width            = 4,
  parameter int hold_count_max   = 62500000,
  parameter int repeat_count_max = 12500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] debounced_signal,
  input  logic [width-1:0] repeat_en,
  output logic [width-1:0] press_pulse,
  output logic [width-1:0] repeat_pulse,
  output logic [width-1:0] release_pulse,
  output logic [width-1:0] held
);

  localparam int CNT_MAX = (hold_count_max > repeat_count_max) ? hold_count_max : repeat_count_max;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(hold_count_max - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(repeat_count_max - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HOLD = 2'd1,
    REPEAT    = 2'd2
  } state_e;

  for (genvar g = 0; g < width; g++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q;
    logic             press_q, press_d;
    logic             repeat_q, repeat_d;
    logic             release_q, release_d;
    logic             held_q;
    logic             rise, fall;

    assign rise = debounced_signal[g] & ~prev_q;
    assign fall = ~debounced_signal[g] & prev_q;

    // Outside IDLE with no edge the input is steadily high, so only the
    // enable and the counter matter here. Release beats a pending repeat.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      repeat_d  = 1'b0;
      release_d = 1'b0;
      if (rise) begin
        press_d = 1'b1;
        state_d = WAIT_HOLD;
        cnt_d   = '0;
      end else if (fall) begin
        release_d = 1'b1;
        state_d   = IDLE;
        cnt_d     = '0;
      end else if (state_q != IDLE) begin
        if (!repeat_en[g]) begin
          state_d = WAIT_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == ((state_q == WAIT_HOLD) ? HOLD_TC : REP_TC)) begin
          repeat_d = 1'b1;
          state_d  = REPEAT;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= IDLE;
        cnt_q     <= '0;
        prev_q    <= 1'b0;
        press_q   <= 1'b0;
        repeat_q  <= 1'b0;
        release_q <= 1'b0;
        held_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        prev_q    <= debounced_signal[g];
        press_q   <= press_d;
        repeat_q  <= repeat_d;
        release_q <= release_d;
        held_q    <= (state_d != IDLE);
      end
    end

    assign press_pulse[g]   = press_q;
    assign repeat_pulse[g]  = repeat_q;
    assign release_pulse[g] = release_q;
    assign held[g]          = held_q;
  end

endmodule

// File: tb/tb_button_repeater.sv
// Bench for button_repeater: expected pulse events are scheduled from the
// latency rules into a queue and compared against the outputs every cycle.
module tb_button_repeater;
  localparam int W = 4;
  localparam int H = 10;
  localparam int R = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] dsig, en;
  logic [W-1:0] press, rep, rel, held;

  always #5 clk = ~clk;

  button_repeater #(.width(W), .hold_count_max(H), .repeat_count_max(R)) dut (
    .clk(clk), .rst_n(rst_n), .debounced_signal(dsig), .repeat_en(en),
    .press_pulse(press), .repeat_pulse(rep), .release_pulse(rel), .held(held)
  );

  typedef struct { int cyc; int ch; int kind; } ev_t;          // kind: 0 press, 1 repeat, 2 release
  typedef struct { int grp; int ch; int start; int len; int n_rep; } vec_t;

  ev_t          sb[$];
  vec_t         vecs[11];
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] exp_held = '0;

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input int ch, input int kind);
    ev_t e;
    e.cyc = c; e.ch = ch; e.kind = kind;
    sb.push_back(e);
  endtask

  // Press seen at s; repeats at s+H, s+H+R, ...; release at s+len.
  task automatic schedule(input int ch, input int s, input int len, input int n_rep);
    push(s, ch, 0);
    for (int k = 0; k < n_rep; k++) push(s + H + k * R, ch, 1);
    push(s + len, ch, 2);
  endtask

  task automatic step();
    logic [W-1:0] ep, er, erl;
    @(posedge clk);
    cyc++;
    #1;
    ep = '0; er = '0; erl = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          0:       ep[sb[i].ch]  = 1'b1;
          1:       er[sb[i].ch]  = 1'b1;
          default: erl[sb[i].ch] = 1'b1;
        endcase
        sb.delete(i);
      end
    end
    exp_held = (exp_held | ep) & ~erl;
    cmp("press_pulse", press, ep);
    cmp("repeat_pulse", rep, er);
    cmp("release_pulse", rel, erl);
    cmp("held", held, exp_held);
  endtask

  task automatic sb_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s leftover_events=%0d expected=0", name, sb.size());
    end
  endtask

  task automatic run_group(input int g);
    int last = 0;
    foreach (vecs[i]) if (vecs[i].grp == g && vecs[i].start + vecs[i].len > last) last = vecs[i].start + vecs[i].len;
    for (int t = 0; t <= last + 3; t++) begin
      foreach (vecs[i]) begin
        if (vecs[i].grp == g) begin
          if (t == vecs[i].start) begin
            dsig[vecs[i].ch] = 1'b1;
            schedule(vecs[i].ch, cyc + 1, vecs[i].len, vecs[i].n_rep);
          end
          if (t == vecs[i].start + vecs[i].len) dsig[vecs[i].ch] = 1'b0;
        end
      end
      step();
    end
    sb_drained($sformatf("group%0d_drained", g));
  endtask

  initial begin
    int c;
    //            grp ch start len n_rep
    vecs[0]  = '{0, 0, 0,  5, 0};   // short press
    vecs[1]  = '{1, 1, 0, 25, 4};   // long press: repeats at 10,14,18,22
    vecs[2]  = '{2, 2, 0, 10, 0};   // release on the terminal-count edge
    vecs[3]  = '{3, 3, 0, 11, 1};   // one cycle past terminal count
    vecs[4]  = '{4, 0, 0,  1, 0};   // single-cycle high
    vecs[5]  = '{5, 0, 0, 12, 1};   // staggered, all channels
    vecs[6]  = '{5, 1, 2, 20, 3};
    vecs[7]  = '{5, 2, 5,  3, 0};
    vecs[8]  = '{5, 3, 7, 15, 2};
    vecs[9]  = '{6, 0, 0,  2, 0};   // release then immediate re-press
    vecs[10] = '{6, 0, 3,  2, 0};

    rst_n = 1'b0;
    dsig  = '1;
    en    = '1;
    for (int i = 0; i < 3; i++) step();

    // Inputs already high when reset lifts: press on all channels at the first edge.
    rst_n = 1'b1;
    c = cyc;
    for (int ch = 0; ch < W; ch++) schedule(ch, c + 1, 3, 0);
    for (int i = 0; i < 3; i++) step();
    dsig = '0;
    for (int i = 0; i < 3; i++) step();
    sb_drained("reset_release_drained");

    for (int g = 0; g <= 6; g++) run_group(g);

    // Repeat disabled for 20 cycles, then enabled: full hold delay restarts.
    en[3] = 1'b0;
    c = cyc;
    dsig[3] = 1'b1;
    push(c + 1, 3, 0);
    for (int i = 0; i < 20; i++) step();
    en[3] = 1'b1;
    push(c + 30, 3, 1);
    push(c + 34, 3, 1);
    push(c + 36, 3, 2);
    for (int i = 0; i < 15; i++) step();
    dsig[3] = 1'b0;
    for (int i = 0; i < 4; i++) step();
    sb_drained("repeat_en_drained");

    // Async reset in the middle of REPEAT: outputs clear immediately, no release.
    c = cyc;
    dsig[1] = 1'b1;
    push(c + 1, 1, 0);
    push(c + 11, 1, 1);
    push(c + 15, 1, 1);
    for (int i = 0; i < 16; i++) step();
    rst_n = 1'b0;
    #2;
    cmp("async_rst_press", press, '0);
    cmp("async_rst_repeat", rep, '0);
    cmp("async_rst_release", rel, '0);
    cmp("async_rst_held", held, '0);
    sb.delete();
    exp_held = '0;
    dsig = '0;
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_repeater.md
# button_repeater

Per-channel press/hold/release event generator sitting directly downstream of the debouncer. It takes debounced button levels and emits single-cycle event pulses: one on press, one on release, and periodic auto-repeat pulses while a button is held. It also exposes a registered held level. Downstream control logic consumes only these pulses and never samples raw button levels.

## Interface
- `width`, default 4: number of independent button channels.
- `hold_count_max`, default 62500000: cycles from the press pulse to the first repeat pulse. Legal range ≥ 2.
- `repeat_count_max`, default 12500000: cycles between successive repeat pulses. Legal range ≥ 2.

- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `debounced_signal`  in  `width`: debounced button levels, synchronous to `clk`.
- `repeat_en`  in  `width`: per-channel auto-repeat enable.
- `press_pulse`  out  `width`: one-cycle pulse on each rising level.
- `repeat_pulse`  out  `width`: one-cycle auto-repeat pulse.
- `release_pulse`  out  `width`: one-cycle pulse on each falling level.
- `held`  out  `width`: high while the channel is in any non-IDLE state.

## Operation
- Each channel is fully independent. Per channel: a previous-level register `prev`, a 2-bit state (IDLE, WAIT_HOLD, REPEAT), and one counter of width `$clog2(max(hold_count_max, repeat_count_max))`.
- All outputs are registered, with no combinational path from input to output.
- Rising edge (`in`=1, `prev`=0) in any state:
  - `press_pulse` goes to 1.
  - State goes to WAIT_HOLD and the counter clears to 0.
- Falling edge (`in`=0, `prev`=1):
  - `release_pulse` goes to 1.
  - State goes to IDLE and the counter clears to 0.
  - No repeat pulse is emitted on this edge, even if the counter is at terminal count. Release wins.
- WAIT_HOLD with `in`=1, `prev`=1, `repeat_en`=1:
  - If counter == `hold_count_max`-1: `repeat_pulse` goes to 1, counter clears to 0, state goes to REPEAT.
  - Otherwise the counter increments.
- REPEAT with `in`=1, `prev`=1, `repeat_en`=1:
  - If counter == `repeat_count_max`-1: `repeat_pulse` goes to 1 and the counter clears to 0.
  - Otherwise the counter increments.
- `repeat_en`=0 in WAIT_HOLD or REPEAT:
  - Counter clears to 0, state goes to WAIT_HOLD, and no repeat pulse is emitted.
  - When `repeat_en` is re-asserted, the full `hold_count_max` delay restarts.
- Pulses last exactly one cycle. Each pulse register defaults to 0 every cycle unless it is set by the rules above.
- At most one of `press_pulse`, `repeat_pulse`, `release_pulse` is high per channel per cycle.
- `held` is a registered copy of (next state != IDLE). It rises in the same cycle as `press_pulse` and falls in the same cycle as `release_pulse`.

## Timing
- Reset (`rst_n`=0, asynchronous): all outputs 0, every `prev` = 0, all states IDLE, all counters 0.
- A channel whose input is already high at reset deassertion sees a rising edge at the first clock. It produces `press_pulse` one cycle later. This is intended behaviour.
- Latency. Let E0 be the first clock edge that samples `in`=1:
  - `press_pulse` and `held` are high in the cycle after E0.
  - The first `repeat_pulse` is high in the cycle after E`hold_count_max`.
  - Subsequent repeat pulses follow every `repeat_count_max` cycles.
- Release latency: `release_pulse` is high in the cycle after the first edge that samples `in`=0.
- Reset asserted mid-hold: outputs drop to 0 immediately, with no release pulse.
- A one-cycle input high produces `press_pulse` and then `release_pulse` in consecutive cycles.

## Test plan
- **Reset level check.** Assert `rst_n`=0 with `debounced_signal`=4'hF. All outputs must read 0 throughout reset. After release, `press_pulse`=4'hF for exactly one cycle, one cycle after the first edge.
- **Short press** (`hold_count_max`=10, `repeat_count_max`=4). Hold ch0 high for 5 cycles, then low.
  - Required: one `press_pulse[0]`, zero repeats, one `release_pulse[0]` one cycle after the falling sample.
  - `held[0]` is high for exactly 5 cycles.
- **Long press** (same parameters). Hold ch1 high for 25 cycles.
  - Required: `repeat_pulse[1]` exactly 10, 14, 18 and 22 cycles after `press_pulse[1]`, then `release_pulse[1]`.
  - No repeat in the release cycle.
- **Release at terminal count.** Drop ch2 on the edge where the counter equals 9. Required: `release_pulse[2]`=1 and `repeat_pulse[2]`=0 in that cycle.
- **Repeat enable toggle.** Hold ch3 with `repeat_en[3]`=0 for 20 cycles, which must give no repeats. Then set it to 1: the first repeat must occur exactly 10 cycles later.
- **Channel independence and async reset.**
  - Run staggered presses on all four channels. Each pulse stream must match its single-channel expectation.
  - Pulse `rst_n` low mid-REPEAT. Outputs must go to 0 without waiting for a clock edge, and no `release_pulse` may appear.
